// File: rtl/timer_ctrl_pkg.sv
// Shared constants and types for the timer controller slice.
//   state_t  : controller FSM encoding, also driven out on the state port
//   TMR_CLR  : code on the timer count input that clears its prescaler
//   step_cnt : one-step up/down move of the 4-bit count (no wrap handling;
//              the controller stops at the terminal value before a wrap)
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TMR_CLR = 4'hF;
  localparam logic [3:0] TMR_NOP = 4'h0;

  function automatic logic [3:0] step_cnt(input logic [3:0] cnt, input logic down);
    return down ? (cnt - 4'd1) : (cnt + 4'd1);
  endfunction

endpackage

// File: rtl/timer_ctrl_timer.sv
// Prescaler timer: while signal is high it counts clocks and raises flag
// for one clock after every TIME enabled clocks. Dropping signal, or
// presenting TMR_CLR on count, restarts the prescaler from zero, so the
// first flag after (re)enable is always a full period away.
//   clk    : clock, rising edge
//   n_rst  : asynchronous active-low reset
//   signal : enable (prescaler held at zero while low)
//   count  : command code; TMR_CLR clears the prescaler
//   flag   : registered one-clock tick
module timer_ctrl_timer import timer_ctrl_pkg::*; #(
  parameter logic [27:0] TIME = 28'h2FA_F080
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       signal,
  input  logic [3:0] count,
  output logic       flag
);

  logic [27:0] pre;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre  <= '0;
      flag <= 1'b0;
    end else if (count == TMR_CLR || !signal) begin
      pre  <= '0;
      flag <= 1'b0;
    end else if (pre == TIME - 28'd1) begin
      pre  <= '0;
      flag <= 1'b1;
    end else begin
      pre  <= pre + 28'd1;
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/done controller around a prescaler timer. A start in IDLE
// latches limit and mode and counts up 0->limit or down limit->0, one step
// per timer tick; stop pauses (discarding the partial prescaler period),
// clear aborts to IDLE from anywhere.
//   clk   : clock, rising edge          n_rst : async active-low reset
//   start : begin / resume request      stop  : pause request
//   clear : abort request               mode  : 0 up, 1 down
//   limit : terminal count (sampled on start from IDLE)
//   count : registered count            run   : high in RUN
//   done  : high in DONE                state : FSM state code
module timer_ctrl import timer_ctrl_pkg::*; #(
  parameter logic [27:0] TIME = 28'h2FA_F080
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       mode,
  input  logic [3:0] limit,
  output logic [3:0] count,
  output logic       run,
  output logic       done,
  output logic [1:0] state
);

  state_t     state_q, state_nxt;
  logic [3:0] count_q, count_nxt;
  logic [3:0] lim_q, lim_nxt;
  logic       mode_q, mode_nxt;
  logic       tick;
  logic [3:0] tmr_cmd;
  logic [3:0] stepped;
  logic [3:0] target;

  // The timer only runs while in RUN, so every RUN entry restarts its
  // prescaler; the clear code also wipes it on an abort.
  assign tmr_cmd = clear ? TMR_CLR : TMR_NOP;

  timer_ctrl_timer #(.TIME(TIME)) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .signal (run),
    .count  (tmr_cmd),
    .flag   (tick)
  );

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    lim_nxt   = lim_q;
    mode_nxt  = mode_q;
    target    = mode_q ? 4'h0 : lim_q;
    stepped   = tick ? step_cnt(count_q, mode_q) : count_q;

    if (clear) begin
      state_nxt = ST_IDLE;
      count_nxt = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            lim_nxt  = limit;
            mode_nxt = mode;
            // A zero limit is already terminal in either direction.
            if (limit == 4'h0) begin
              state_nxt = ST_DONE;
              count_nxt = '0;
            end else begin
              state_nxt = ST_RUN;
              count_nxt = mode ? limit : 4'h0;
            end
          end
        end
        ST_RUN: begin
          // A tick coinciding with stop still counts; reaching the
          // terminal value wins over the pause.
          count_nxt = stepped;
          if (tick && stepped == target) state_nxt = ST_DONE;
          else if (stop)                 state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      lim_q   <= lim_nxt;
      mode_q  <= mode_nxt;
    end
  end

  assign count = count_q;
  assign run   = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  localparam int TIME_TB = 4;

  logic       clk;
  logic       n_rst;
  logic       start, stop, clear, mode;
  logic [3:0] limit;
  logic [3:0] count;
  logic       run, done;
  logic [1:0] state;

  int n_chk;
  int n_pass;

  // Reference model: state codes 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; the
  // prescaler is modelled as elapsed clocks since the last RUN entry.
  int m_state, m_count, m_lim, m_mode, m_age;

  timer_ctrl #(.TIME(28'd4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .stop  (stop),
    .clear (clear),
    .mode  (mode),
    .limit (limit),
    .count (count),
    .run   (run),
    .done  (done),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_lim = 0; m_mode = 0; m_age = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit cl,
                            input int lim_in, input bit md_in);
    bit tick;
    tick = 1'b0;
    if (m_state == 1) begin
      m_age++;
      tick = (m_age >= TIME_TB + 1) && (((m_age - 1) % TIME_TB) == 0);
    end
    if (cl) begin
      m_state = 0; m_count = 0;
    end else if (m_state == 0) begin
      if (st) begin
        m_lim = lim_in; m_mode = md_in;
        if (lim_in == 0) begin m_state = 3; m_count = 0; end
        else begin m_state = 1; m_age = 0; m_count = md_in ? lim_in : 0; end
      end
    end else if (m_state == 1) begin
      if (tick) m_count = m_mode ? m_count - 1 : m_count + 1;
      if (tick && m_count == (m_mode ? 0 : m_lim)) m_state = 3;
      else if (sp) m_state = 2;
    end else if (m_state == 2) begin
      if (st) begin m_state = 1; m_age = 0; end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit st, input bit sp, input bit cl,
                     input int lim_in, input bit md_in);
    start = st; stop = sp; clear = cl; limit = 4'(lim_in); mode = md_in;
    @(posedge clk);
    model_edge(st, sp, cl, lim_in, md_in);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("run",   32'(run),   32'(m_state == 1));
    check_eq("done",  32'(done),  32'(m_state == 3));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_run",   32'(run),   32'd0);
    check_eq("rst_done",  32'(done),  32'd0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    n_rst = 1'b0; start = 0; stop = 0; clear = 0; mode = 0; limit = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    // Up count to 3: steps land 5, 9, 13 clocks after RUN entry.
    cyc(1, 0, 0, 3, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (i == 4 || i == 5 || i == 9 || i == 13)
        check_eq("up_step", 32'(count), (i >= 13) ? 32'd3 : (i >= 9) ? 32'd2 : (i >= 5) ? 32'd1 : 32'd0);
    end
    check_eq("up_done", 32'(done), 32'd1);
    check_eq("up_run",  32'(run),  32'd0);

    // Down count from 2, start ignored in DONE, clear back to IDLE.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 2, 1);
    check_eq("dn_load", 32'(count), 32'd2);
    idle(10);
    check_eq("dn_state", 32'(state), 32'd3);
    cyc(1, 0, 0, 7, 0);
    check_eq("dn_ign_start", 32'(state), 32'd3);
    cyc(0, 0, 1, 0, 0);
    check_eq("dn_clr_count", 32'(count), 32'd0);
    check_eq("dn_clr_state", 32'(state), 32'd0);

    // Pause at 2 for 20 clocks, resume: next step 5 clocks later.
    cyc(1, 0, 0, 5, 0);
    idle(9);
    cyc(0, 1, 0, 0, 0);
    check_eq("pz_state", 32'(state), 32'd2);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (i == 19) check_eq("pz_hold", 32'(count), 32'd2);
    end
    cyc(1, 0, 0, 0, 0);
    idle(4);
    check_eq("rs_before", 32'(count), 32'd2);
    idle(1);
    check_eq("rs_step", 32'(count), 32'd3);

    // Stop coincident with tick at count 1; clear coincident with tick.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 5, 0);
    idle(8);
    check_eq("co_pre", 32'(count), 32'd1);
    cyc(0, 1, 0, 0, 0);
    check_eq("co_count", 32'(count), 32'd2);
    check_eq("co_state", 32'(state), 32'd2);
    cyc(1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 1, 0, 0);
    check_eq("cc_count", 32'(count), 32'd0);
    check_eq("cc_state", 32'(state), 32'd0);

    // Zero limit goes straight to DONE; reset mid-RUN at count 3.
    cyc(1, 0, 0, 0, 0);
    check_eq("z_state", 32'(state), 32'd3);
    check_eq("z_run", 32'(run), 32'd0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 5, 0);
    idle(13);
    check_eq("mr_pre", 32'(count), 32'd3);
    do_reset();
    idle(6);

    // Full-range limit in both directions.
    cyc(1, 0, 0, 15, 0);
    idle(61);
    check_eq("f_up", 32'(count), 32'd15);
    check_eq("f_up_done", 32'(done), 32'd1);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 15, 1);
    idle(61);
    check_eq("f_dn", 32'(count), 32'd0);
    cyc(0, 0, 1, 0, 0);

    // Randomized traffic, including coincident requests and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
               $urandom_range(0, 59) == 0, int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TIME, default 28'h2FA_F080, prescaler terminal value (clocks per tick) passed to the timer instance.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin or resume counting.
REQ-005 SHALL have port stop  input  1  single-cycle request to pause counting.
REQ-006 SHALL have port clear  input  1  single-cycle request to abort and return to idle.
REQ-007 SHALL have port mode  input  1  0 = count up 0->limit, 1 = count down limit->0.
REQ-008 SHALL have port limit  input  4  terminal count, sampled only on start from IDLE.
REQ-009 SHALL have port count  output  4  current count value, registered.
REQ-010 SHALL have port run  output  1  high while in RUN; drives the timer signal input.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.

Function
REQ-013 SHALL implement FSM IDLE, RUN, PAUSE, DONE; request priority clear > stop > start.
REQ-014 SHALL, in any state on clear, go to IDLE next edge with count = 0.
REQ-015 SHALL, in IDLE on start, latch limit and mode; count loads 0 (up) or limit (down); go to RUN.
REQ-016 SHALL, on start in IDLE with limit = 0, go directly to DONE with count = 0; run never asserts.
REQ-017 SHALL, in RUN on stop, go to PAUSE; in PAUSE on start, return to RUN; count held in PAUSE.
REQ-018 SHALL ignore start in RUN and DONE, and stop in IDLE, PAUSE, DONE.
REQ-019 SHALL act on tick (timer flag) only when state = RUN; ticks in other states are discarded.
REQ-020 SHALL, on tick in RUN, increment (up) or decrement (down) count by 1, 4-bit, no wrap.
REQ-021 SHALL go to DONE on the same edge that count reaches latched limit (up) or 0 (down); count holds there.
REQ-022 SHALL, on tick and stop in the same cycle in RUN, apply the count step and enter PAUSE (or DONE if terminal reached).
REQ-023 SHALL, on tick and clear in the same cycle, discard the tick and enter IDLE.
REQ-024 SHALL accept the timer prescaler restarting on every RUN entry, so pause discards the partial period.
REQ-025 SHALL drive the timer count input with 4'hF during the clear cycle and 4'h0 otherwise.
REQ-026 SHALL produce first count change TIME+1 clocks after the edge entering RUN, then every TIME clocks.
REQ-027 SHALL produce run, done, state as pure decodes of the state register (no extra latency).
REQ-028 SHALL support limit = 4'hF in both modes without stalling the prescaler.

Reset
REQ-029 SHALL on n_rst low force state = IDLE, count = 0, latched limit = 0, latched mode = 0, run = 0, done = 0.
REQ-030 SHALL reset the timer instance from the same n_rst; reset mid-RUN aborts with no tick counted.
REQ-031 SHALL resume normal operation on the first rising clk edge after n_rst deasserts.

Structure
REQ-032 SHALL instantiate exactly one sub-module, the existing timer, with TIME passed through.
REQ-033 SHALL place state encodings (IDLE..DONE) and the 4'hF timer-clear code as constants in the shared project package.
REQ-034 SHALL hold the FSM and count in one clocked process with separate next-state logic.

Verification (TIME = 4 in bench)
REQ-035 SHALL test: mode=0, limit=3, start -> count 1,2,3 at 5, 9, 13 clocks after RUN entry; DONE, done=1, run=0 after third tick.
REQ-036 SHALL test: mode=1, limit=2, start -> count 2,1,0; DONE on 0; subsequent start ignored; clear -> IDLE, count=0.
REQ-037 SHALL test: limit=5 up, stop after count=2, hold 20 clocks, start -> count stays 2 through PAUSE; next step 5 clocks after resume.
REQ-038 SHALL test: stop coincident with tick at count=1 -> count=2, state=PAUSE; clear coincident with tick -> IDLE, count=0.
REQ-039 SHALL test: limit=0 start -> DONE next edge, run never high; n_rst pulse mid-RUN at count=3 -> all outputs 0, state IDLE.
